mem_lsu: RTL and testbench

// MEM-stage load/store unit between the EX/MEM pipeline register and a data memory with variable latency.

---
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lsu.sv | 170 +++++++++++++++++
 tb/tb_mem_lsu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data memory request/response bus between the LSU and data memory
interface mem_lsu_if;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ready_i;
  logic [31:0] dm_rdata_i;

  modport master (
    output dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
    input  dm_ready_i, dm_rdata_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o,
    output dm_ready_i, dm_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with held requests, lane alignment and a timeout watchdog
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  input  logic        mem_load_i,
  input  logic        mem_store_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  mem_lsu_if.master   dm
);
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_req, r_we, r_uns, r_load_valid, r_misalign, r_bus_err;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_load_data;
  logic [1:0]  r_size, r_lane;

  logic        w_aligned, w_legal, w_timeout;
  logic        w_capture, w_reject, w_complete, w_expire, w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_extract;

  always_comb begin
    w_aligned = 1'b0;
    case (mem_size_i)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~mem_addr_i[0];
      2'b10:   w_aligned = (mem_addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_legal   = mem_valid_i & (mem_load_i ^ mem_store_i) & w_aligned;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1)) && !dm.dm_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_legal) w_next = S_REQ;
      S_REQ:   if (dm.dm_ready_i || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture  = 1'b0;
    w_reject   = 1'b0;
    w_complete = 1'b0;
    w_expire   = 1'b0;
    w_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_capture = w_legal;
        w_reject  = mem_valid_i & ~w_legal;
        w_stall   = w_legal;
      end
      S_REQ: begin
        w_stall    = 1'b1;
        w_complete = dm.dm_ready_i;
        w_expire   = w_timeout;
      end
      default: ;
    endcase
  end

  // Reset must force every output low even while an op is still presented.
  assign stall_o = w_stall & ~reset;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_wdata_i;
    case (mem_size_i)
      2'b00: begin
        w_be    = 4'b0001 << mem_addr_i[1:0];
        w_wdata = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halves are aligned, so shifting by 8*lane also gives 16*addr[1].
  assign w_shifted = dm.dm_rdata_i >> {r_lane, 3'b000};

  always_comb begin
    w_extract = dm.dm_rdata_i;
    case (r_size)
      2'b00:   w_extract = r_uns ? {24'b0, w_shifted[7:0]}  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_extract = r_uns ? {16'b0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 4'b0;
      r_addr       <= 32'b0;
      r_wdata      <= 32'b0;
      r_size       <= 2'b0;
      r_lane       <= 2'b0;
      r_uns        <= 1'b0;
      r_load_data  <= 32'b0;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      r_misalign   <= w_reject;
      r_cnt        <= (r_state == S_REQ) ? r_cnt + 1'b1 : '0;
      if (w_capture) begin
        r_req   <= 1'b1;
        r_we    <= mem_store_i;
        r_be    <= w_be;
        r_addr  <= {mem_addr_i[31:2], 2'b00};
        r_wdata <= w_wdata;
        r_size  <= mem_size_i;
        r_lane  <= mem_addr_i[1:0];
        r_uns   <= mem_unsigned_i;
      end
      if (w_complete) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_load_data  <= w_extract;
          r_load_valid <= 1'b1;
        end
      end else if (w_expire) begin
        r_req       <= 1'b0;
        r_bus_err   <= 1'b1;
        r_load_data <= 32'b0;
      end
    end
  end

  assign dm.dm_req_o   = r_req;
  assign dm.dm_we_o    = r_we;
  assign dm.dm_be_o    = r_be;
  assign dm.dm_addr_o  = r_addr;
  assign dm.dm_wdata_o = r_wdata;
  assign load_data_o   = r_load_data;
  assign load_valid_o  = r_load_valid;
  assign misalign_o    = r_misalign;
  assign bus_err_o     = r_bus_err;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu with a latency-programmable memory responder
module tb_mem_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid_i = 1'b0, mem_load_i = 1'b0, mem_store_i = 1'b0, mem_unsigned_i = 1'b0;
  logic [1:0]  mem_size_i = 2'b0;
  logic [31:0] mem_addr_i = 32'b0, mem_wdata_i = 32'b0;
  logic        stall_o, load_valid_o, misalign_o, bus_err_o;
  logic [31:0] load_data_o;

  mem_lsu_if dm();

  mem_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_valid_i(mem_valid_i), .mem_load_i(mem_load_i), .mem_store_i(mem_store_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dm(dm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic        last_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mdl_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0: case (a[1:0]) 2'd0: return 4'b0001; 2'd1: return 4'b0010; 2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'd1: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mdl_wd(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0: return {w[7:0], w[7:0], w[7:0], w[7:0]};
      2'd1: return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] mdl_ld(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0: return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1: return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  // kind: 0 load, 1 store, 2 rejected, 3 timeout. dly = REQ cycles before ready.
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int dly, input int kind, input logic [31:0] exp_ld);
    int   reqc = 0, stc = 0, lvc = 0, mac = 0, bec = 0, exp_reqc;
    logic done = 1'b0, stall_last;
    req_t r, e;
    mem_valid_i = 1'b1; mem_load_i = ld; mem_store_i = st; mem_size_i = sz;
    mem_unsigned_i = u; mem_addr_i = a; mem_wdata_i = wd; dm.dm_rdata_i = rd;
    if (kind != 2) begin
      r.we = st; r.be = mdl_be(sz, a); r.addr = {a[31:2], 2'b00}; r.wd = mdl_wd(sz, wd);
      exp_req_q.push_back(r);
    end
    if (kind == 0) exp_load_q.push_back(exp_ld);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dm.dm_req_o) begin
        reqc++;
        if (reqc == 1) begin
          last_be = dm.dm_be_o; last_wd = dm.dm_wdata_o; last_we = dm.dm_we_o;
          if (exp_req_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_req_q.pop_front();
            check("req_we", {31'b0, dm.dm_we_o}, {31'b0, e.we});
            check("req_be", {28'b0, dm.dm_be_o}, {28'b0, e.be});
            check("req_addr", dm.dm_addr_o, e.addr);
            if (e.we) check("req_wdata", dm.dm_wdata_o, e.wd);
          end
        end
      end
      if (stall_o) stc++;
      if (load_valid_o) begin
        lvc++;
        if (exp_load_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
        else check("load_data", load_data_o, exp_load_q.pop_front());
      end
      if (misalign_o) mac++;
      if (bus_err_o) begin
        bec++;
        check("buserr_data", load_data_o, 32'h0);
      end
      dm.dm_ready_i = dm.dm_req_o && (reqc > dly);
      stall_last = stall_o;
      done = load_valid_o | misalign_o | bus_err_o | ((reqc > 0) && !dm.dm_req_o);
      if (done) break;
      @(posedge clk); #1;
      if (!stall_last) mem_valid_i = 1'b0;
    end
    check("op_done", {31'b0, done}, 32'd1);
    exp_reqc = (kind == 2) ? 0 : (kind == 3) ? TMO : dly + 1;
    check("req_cycles", reqc, exp_reqc);
    check("stall_cycles", stc, (kind == 2) ? 0 : exp_reqc + 1);
    check("load_valid_cnt", lvc, (kind == 0) ? 1 : 0);
    check("misalign_cnt", mac, (kind == 2) ? 1 : 0);
    check("bus_err_cnt", bec, (kind == 3) ? 1 : 0);
    @(posedge clk); #1;
    mem_valid_i = 1'b0; dm.dm_ready_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a, w, rd;
    logic        st, u;
    int          dly;
    dm.dm_ready_i = 1'b0; dm.dm_rdata_i = 32'b0;
    @(negedge clk);
    check("rst_req", {31'b0, dm.dm_req_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_pulses", {29'b0, load_valid_o, misalign_o, bus_err_o}, 32'd0);
    check("rst_data", load_data_o, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    do_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
    do_op(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80AA55CC, 0, 0, 32'hFFFFFF80);
    check("lb_be", {28'b0, last_be}, 32'h8);
    do_op(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80AA55CC, 0, 0, 32'h00000080);
    do_op(0, 1, 2'd1, 0, 32'h22, 32'h1234ABCD, 32'h0, 0, 1, 32'h0);
    check("sh_be", {28'b0, last_be}, 32'hC);
    check("sh_wdata", last_wd, 32'hABCDABCD);
    check("sh_we", {31'b0, last_we}, 32'd1);
    do_op(1, 0, 2'd1, 0, 32'h22, 32'h0, 32'h80010000, 2, 0, 32'hFFFF8001);
    do_op(1, 0, 2'd1, 1, 32'h22, 32'h0, 32'h80010000, 0, 0, 32'h00008001);
    do_op(1, 0, 2'd1, 0, 32'h21, 32'h0, 32'h0, 0, 2, 32'h0);
    do_op(1, 0, 2'd2, 0, 32'h02, 32'h0, 32'h0, 0, 2, 32'h0);
    do_op(1, 0, 2'd3, 0, 32'h00, 32'h0, 32'h0, 0, 2, 32'h0);
    do_op(1, 1, 2'd2, 0, 32'h00, 32'h0, 32'h0, 0, 2, 32'h0);
    do_op(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h0, 100, 3, 32'h0);

    // Reset while the request is outstanding.
    mem_valid_i = 1'b1; mem_load_i = 1'b1; mem_store_i = 1'b0; mem_size_i = 2'd2; mem_addr_i = 32'h40;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req_before", {31'b0, dm.dm_req_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req", {31'b0, dm.dm_req_o}, 32'd0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_pulses", {29'b0, load_valid_o, misalign_o, bus_err_o}, 32'd0);
    end
    mem_valid_i = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    do_op(1, 0, 2'd2, 0, 32'h44, 32'h0, 32'h01234567, 0, 0, 32'h01234567);

    for (int i = 0; i < 12; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      st = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      w = $urandom; rd = $urandom;
      dly = $urandom_range(0, 2);
      do_op(~st, st, sz, u, a, w, rd, dly, st ? 1 : 0, mdl_ld(sz, u, a, rd));
    end

    check("sb_req_empty", exp_req_q.size(), 0);
    check("sb_load_empty", exp_load_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
